// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter with transmit FIFO; UART_TX_BREAK_EN adds line-break generation
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPB_W      = 13
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef UART_TX_BREAK_EN
  input  logic                          brk_req,
`endif
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic [CPB_W-1:0]              clk_per_bit,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0] L_FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK
`endif
  } state_t;
  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [AW:0]         r_level;
  logic [DATA_W-1:0]   r_shift;
  logic [CPB_W-1:0]    r_cpb, r_cnt, w_cpb_eff;
  logic [BW-1:0]       r_bit;
  logic                r_stop_idx, r_stop2, r_par_en, r_par, r_tx;
  logic                w_push, w_empty, w_bit_end, w_last_stop, w_frame_end, w_sel, w_load, w_cnt_clr;
`ifdef UART_TX_BREAK_EN
  logic                r_mab;
`endif
  assign s_ready     = r_level != L_FULL;
  assign w_empty     = r_level == '0;
  assign w_push      = s_valid && s_ready;
  assign w_cpb_eff   = (clk_per_bit < CPB_W'(2)) ? CPB_W'(2) : clk_per_bit;
  assign w_bit_end   = r_cnt == r_cpb - CPB_W'(1);
  assign w_last_stop = r_stop_idx == r_stop2;
  assign w_frame_end = r_state == S_STOP && w_bit_end && w_last_stop;
  assign w_sel       = r_state == S_IDLE || w_frame_end;
`ifdef UART_TX_BREAK_EN
  assign w_load      = w_sel && !w_empty && !brk_req;
  assign w_cnt_clr   = w_bit_end || r_state == S_IDLE || (r_state == S_BREAK && !r_mab);
`else
  assign w_load      = w_sel && !w_empty;
  assign w_cnt_clr   = w_bit_end || r_state == S_IDLE;
`endif
  assign tx          = r_tx;
  assign busy        = r_state != S_IDLE;
  assign tx_done     = w_frame_end;
  assign fifo_level  = r_level;

  // Next-state: advance on bit boundaries; a pop (or break) at a decision point overrides
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_START:  if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:   if (w_bit_end && r_bit == BW'(DATA_W-1)) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:   if (w_frame_end) w_state_nxt = S_IDLE;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  if (r_mab && w_bit_end) w_state_nxt = S_IDLE;
`endif
      default: ;
    endcase
    if (w_load) w_state_nxt = S_START;
`ifdef UART_TX_BREAK_EN
    else if (w_sel && brk_req) w_state_nxt = S_BREAK;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FIFO pointers and occupancy; full/empty come from the level only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_load);
    end
  end

  // FIFO storage, no reset needed since the level gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // Serialiser: latches word and config at pop, shifts bits out on bit boundaries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_cnt      <= '0;
      r_cpb      <= CPB_W'(2);
      r_shift    <= '0;
      r_bit      <= '0;
      r_stop_idx <= 1'b0;
      r_stop2    <= 1'b0;
      r_par_en   <= 1'b0;
      r_par      <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_mab      <= 1'b0;
`endif
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CPB_W'(1);
      if (w_load) begin
        r_shift    <= r_mem[r_rd_ptr];
        r_par      <= (parity_mode == 2'b10) ? ~^r_mem[r_rd_ptr] : ^r_mem[r_rd_ptr];
        r_par_en   <= ^parity_mode;
        r_stop2    <= stop2;
        r_cpb      <= w_cpb_eff;
        r_bit      <= '0;
        r_stop_idx <= 1'b0;
        r_tx       <= 1'b0;
      end
`ifdef UART_TX_BREAK_EN
      else if (w_sel && brk_req) begin
        r_tx  <= 1'b0;
        r_cpb <= w_cpb_eff;
        r_mab <= 1'b0;
      end else if (r_state == S_BREAK && !r_mab && !brk_req) begin
        r_mab <= 1'b1;
        r_tx  <= 1'b1;
      end
`endif
      else if (w_bit_end) begin
        case (r_state)
          S_START:  r_tx <= r_shift[0];
          S_DATA: begin
            if (r_bit == BW'(DATA_W-1)) r_tx <= r_par_en ? r_par : 1'b1;
            else begin
              r_bit   <= r_bit + BW'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
          S_PARITY: r_tx <= 1'b1;
          S_STOP:   r_stop_idx <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: directed checks of framing, parity, FIFO, config latch, reset and break
module tb_uart_tx_fifo_param;
  logic        clk = 0, rst = 1, s_valid = 0, stop2 = 0;
  logic [7:0]  s_data = 0;
  logic [12:0] cpb = 4;
  logic [1:0]  pm = 0;
  logic        s_ready, tx, busy, tx_done;
  logic [2:0]  fifo_level;
`ifdef UART_TX_BREAK_EN
  logic        brk_req = 0;
`endif
  int n_checks = 0, n_pass = 0, mark = 0;
  bit txq[$], dq[$], eq[$];

  uart_tx_fifo_param dut (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk_req(brk_req),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .clk_per_bit(cpb),
    .parity_mode(pm), .stop2(stop2), .tx(tx), .busy(busy), .tx_done(tx_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // log line and done pulse every cycle, away from the active edge
  always @(negedge clk) begin
    txq.push_back(tx);
    dq.push_back(tx_done);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add_idle(input int n, input bit v);
    repeat (n) eq.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] d, input int c, input logic [1:0] p, input bit s2);
    int  e, nb;
    bit  pe, pb, v;
    e  = (c < 2) ? 2 : c;
    pe = (p == 2'b01 || p == 2'b10);
    pb = (p == 2'b10) ? ~^d : ^d;
    nb = 10 + int'(pe) + int'(s2);
    for (int b = 0; b < nb; b++) begin
      if (b == 0) v = 0;
      else if (b <= 8) v = d[b-1];
      else if (pe && b == 9) v = pb;
      else v = 1;
      repeat (e) eq.push_back(v);
    end
  endtask

  task automatic setup();
    mark = txq.size();
    eq.delete();
    add_idle(2, 1);
  endtask

  task automatic push(input logic [7:0] d);
    bit acc;
    acc = 0;
    s_valid = 1;
    s_data = d;
    for (int i = 0; i < 500 && !acc; i++) begin
      acc = s_ready;
      tick();
    end
    s_valid = 0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic verify(input string tag, input int exp_done);
    int t, errs, dn;
    t = 0; errs = 0; dn = 0;
    while (txq.size() < mark + eq.size() && t < 10000) begin
      tick();
      t++;
    end
    check({tag, "_timeout"}, int'(t < 10000), 1);
    for (int i = 0; i < eq.size(); i++) begin
      if (mark + i < txq.size()) begin
        if (txq[mark+i] != eq[i]) errs++;
        dn += int'(dq[mark+i]);
      end else errs++;
    end
    check({tag, "_tx"}, errs, 0);
    check({tag, "_done"}, dn, exp_done);
  endtask

  initial begin
    int dn;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 1);
    rst = 0;
    tick();

    // single frame, 8N1, 4 clocks per bit
    setup(); add_frame(8'hA5, 4, 2'b00, 0); add_idle(1, 1);
    push(8'hA5);
    check("t1_level_push", fifo_level, 1);
    tick();
    check("t1_busy", busy, 1);
    check("t1_level_pop", fifo_level, 0);
    verify("t1", 1);
    check("t1_idle", busy, 0);

    // even and odd parity
    pm = 2'b01;
    setup(); add_frame(8'hA5, 4, 2'b01, 0); add_idle(1, 1);
    push(8'hA5);
    verify("t2_even", 1);
    check("t2_even_bit", txq[mark+2+36], 0);
    pm = 2'b10;
    setup(); add_frame(8'hA5, 4, 2'b10, 0); add_idle(1, 1);
    push(8'hA5);
    verify("t2_odd", 1);
    check("t2_odd_bit", txq[mark+2+36], 1);
    pm = 2'b00;

    // FIFO fill, full ignore, back-to-back frames
    cpb = 2;
    setup();
    for (int d = 1; d <= 5; d++) add_frame(8'(d), 2, 2'b00, 0);
    add_idle(1, 1);
    for (int d = 1; d <= 5; d++) push(8'(d));
    check("t3_full_level", fifo_level, 4);
    check("t3_full_ready", s_ready, 0);
    s_valid = 1; s_data = 8'h66;
    tick();
    s_valid = 0;
    check("t3_ignored", fifo_level, 4);
    verify("t3", 5);
    check("t3_empty", fifo_level, 0);

    // config change mid-frame only affects the next frame
    cpb = 4; stop2 = 0;
    setup(); add_frame(8'h3C, 4, 2'b00, 0); add_frame(8'hC3, 8, 2'b00, 1); add_idle(1, 1);
    push(8'h3C);
    repeat (6) tick();
    stop2 = 1; cpb = 8;
    push(8'hC3);
    verify("t4", 2);
    stop2 = 0; cpb = 4;

    // async reset mid-frame with words queued
    setup();
    push(8'h11); push(8'h22); push(8'h33);
    check("t5_queued", fifo_level, 2);
    repeat (10) tick();
    rst = 1;
    #1;
    check("t5_rst_tx", tx, 1);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", s_ready, 1);
    tick(); tick();
    rst = 0;
    tick();
    dn = 0;
    for (int i = mark; i < txq.size(); i++) dn += int'(dq[i]);
    check("t5_no_done", dn, 0);
    cpb = 0;
    setup(); add_frame(8'h5A, 0, 2'b00, 0); add_idle(1, 1);
    push(8'h5A);
    verify("t5_clamp", 1);
    cpb = 4;

`ifdef UART_TX_BREAK_EN
    // break with a word queued, then mark-after-break and the frame
    mark = txq.size();
    eq.delete();
    add_idle(1, 1); add_idle(20, 0); add_idle(5, 1);
    add_frame(8'hA5, 4, 2'b00, 0); add_idle(1, 1);
    brk_req = 1; s_valid = 1; s_data = 8'hA5;
    tick();
    s_valid = 0;
    repeat (9) tick();
    check("t6_brk_busy", busy, 1);
    check("t6_brk_nopop", fifo_level, 1);
    repeat (10) tick();
    brk_req = 0;
    verify("t6", 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
